// File: rtl/conv_result_relu_serializer.sv
// Captures a conv result tile (ReLU on write) into a 2-slot tile FIFO and streams it one element per cycle.
// Latency: first element one cycle after capture into an empty FIFO. Backpressure: out_* held while !out_ready.
module conv_result_relu_serializer #(
  parameter int PARA_X     = 3,
  parameter int PARA_Y     = 3,
  parameter int DATA_WIDTH = 16,
  parameter int RELU_EN    = 1,
  localparam int N  = PARA_X * PARA_Y,
  localparam int XW = (PARA_X > 1) ? $clog2(PARA_X) : 1,
  localparam int YW = (PARA_Y > 1) ? $clog2(PARA_Y) : 1,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         result_ready,
  input  logic [N*DATA_WIDTH-1:0]      result_buffer,
  output logic                         result_taken,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [XW-1:0]                out_x,
  output logic [YW-1:0]                out_y,
  output logic                         out_last,
  output logic [1:0]                   tiles_pending
);

  typedef logic [DATA_WIDTH-1:0] elem_t;

  function automatic elem_t relu(input elem_t e);
    if (RELU_EN != 0 && e[DATA_WIDTH-1]) return '0;
    return e;
  endfunction

  elem_t          mem_q [2][N];
  elem_t          tile_in [N];

  logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           armed_q, armed_d, taken_q, taken_d;
  logic           valid_q, valid_d, last_q, last_d;
  elem_t          data_q, data_d;
  logic [IW-1:0]  idx_q, idx_d, idx_nx;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           capture, pop, pop_last, start;
  elem_t          start_dat;

  // A full FIFO refuses capture on the registered count, even if a pop drains a slot this cycle.
  assign capture  = result_ready && !armed_q && (count_q != 2'd2);
  assign pop      = valid_q && out_ready;
  assign pop_last = pop && last_q;

  always_comb begin
    for (int i = 0; i < N; i++) tile_in[i] = relu(result_buffer[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q ^ capture;
    rd_ptr_d  = rd_ptr_q ^ pop_last;
    count_d   = count_q + 2'(capture) - 2'(pop_last);
    armed_d   = result_ready && (armed_q || capture);
    taken_d   = capture;
    valid_d   = valid_q;
    data_d    = data_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    last_d    = last_q;
    idx_nx    = idx_q + IW'(1);
    start     = 1'b0;
    start_dat = mem_q[rd_ptr_q][0];

    if (!valid_q && count_q != 2'd0) begin
      start = 1'b1;
    end else if (pop && !last_q) begin
      idx_d  = idx_nx;
      data_d = mem_q[rd_ptr_q][idx_nx];
      last_d = (idx_nx == IW'(N - 1));
      if (x_q == XW'(PARA_X - 1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else if (pop_last) begin
      // Back-to-back tile: either already stored, or arriving this very edge (forwarded).
      if (count_q == 2'd2) begin
        start     = 1'b1;
        start_dat = mem_q[~rd_ptr_q][0];
      end else if (capture) begin
        start     = 1'b1;
        start_dat = tile_in[0];
      end else begin
        valid_d = 1'b0;
      end
    end

    if (start) begin
      valid_d = 1'b1;
      data_d  = start_dat;
      idx_d   = '0;
      x_d     = '0;
      y_d     = '0;
      last_d  = (N == 1);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) mem_q[wr_ptr_q][i] <= tile_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      armed_q  <= 1'b0;
      taken_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      armed_q  <= armed_d;
      taken_q  <= taken_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign result_taken  = taken_q;
  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_x         = x_q;
  assign out_y         = y_q;
  assign out_last      = last_q;
  assign tiles_pending = count_q;

endmodule

// File: tb/tb_conv_result_relu_serializer.sv
// Scoreboard bench: ReLU and pass-through instances share stimulus; a negedge monitor checks every beat.
module tb_conv_result_relu_serializer;
  localparam int N = 9;
  typedef logic [15:0] tile_t [N];
  typedef struct packed {logic [15:0] d; logic [1:0] x; logic [1:0] y; logic l;} beat_t;

  logic clk = 1'b0, rst = 1'b1, result_ready = 1'b0, out_ready = 1'b1;
  logic [N*16-1:0] result_buffer = '0;
  logic rt1, ov1, ol1, rt0, ov0, ol0;
  logic [15:0] od1, od0;
  logic [1:0] ox1, oy1, tp1, ox0, oy0, tp0;

  int vectors = 0, miscompares = 0, beats = 0, taken_cnt = 0, taken_beats = 0;
  beat_t q1[$], q0[$];
  tile_t ta, ta_r, tb, tb_r, tc, tc_r;

  conv_result_relu_serializer #(.PARA_X(3), .PARA_Y(3), .DATA_WIDTH(16), .RELU_EN(1)) dut1 (
    .clk(clk), .rst(rst), .result_ready(result_ready), .result_buffer(result_buffer),
    .result_taken(rt1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_x(ox1), .out_y(oy1), .out_last(ol1), .tiles_pending(tp1));

  conv_result_relu_serializer #(.PARA_X(3), .PARA_Y(3), .DATA_WIDTH(16), .RELU_EN(0)) dut0 (
    .clk(clk), .rst(rst), .result_ready(result_ready), .result_buffer(result_buffer),
    .result_taken(rt0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_x(ox0), .out_y(oy0), .out_last(ol0), .tiles_pending(tp0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst) begin
      if (rt1) begin
        taken_cnt++;
        taken_beats = beats;
      end
      if (ov1 && out_ready) begin
        beats++;
        if (q1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL relu_unexpected_beat: got data %h with no expected beat", od1);
        end else begin
          e = q1.pop_front();
          check("relu_beat{x,y,last,data}", {11'd0, ox1, oy1, ol1, od1}, {11'd0, e.x, e.y, e.l, e.d});
        end
      end
      if (ov0 && out_ready) begin
        if (q0.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL raw_unexpected_beat: got data %h with no expected beat", od0);
        end else begin
          e = q0.pop_front();
          check("raw_beat{x,y,last,data}", {11'd0, ox0, oy0, ol0, od0}, {11'd0, e.x, e.y, e.l, e.d});
        end
      end
    end
  end

  task automatic push_exp(input tile_t raw, input tile_t rl);
    beat_t e;
    for (int i = 0; i < N; i++) begin
      e.x = 2'(i % 3);
      e.y = 2'(i / 3);
      e.l = (i == N - 1);
      e.d = rl[i];
      q1.push_back(e);
      e.d = raw[i];
      q0.push_back(e);
    end
    for (int i = 0; i < N; i++) result_buffer[i*16 +: 16] = raw[i];
  endtask

  task automatic offer(input tile_t raw, input tile_t rl, input int budget);
    bit ok;
    ok = 1'b0;
    push_exp(raw, rl);
    result_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rt1) begin ok = 1'b1; break; end
    end
    check("offer_taken", 32'(ok), 32'd1);
    @(posedge clk); #1 result_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (q1.size() == 0 && q0.size() == 0 && !ov1 && !ov0) begin done = 1'b1; break; end
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin : stim
    int start, tc0;
    bit found;
    ta   = '{16'h3c00, 16'hc000, 16'h4200, 16'h8000, 16'h4400, 16'hfc00, 16'h0000, 16'h7e00, 16'h4000};
    ta_r = '{16'h3c00, 16'h0000, 16'h4200, 16'h0000, 16'h4400, 16'h0000, 16'h0000, 16'h7e00, 16'h4000};
    tb   = '{16'h8001, 16'h0001, 16'h7c00, 16'hffff, 16'h7fff, 16'h3555, 16'hbc00, 16'h0400, 16'h8400};
    tb_r = '{16'h0000, 16'h0001, 16'h7c00, 16'h0000, 16'h7fff, 16'h3555, 16'h0000, 16'h0400, 16'h0000};
    tc   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999};
    tc_r = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h0000, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ov1), 0);
    check("rst_taken", 32'(rt1), 0);
    check("rst_pending", 32'(tp1), 0);
    check("rst_data", 32'(od1), 0);
    check("rst_xy_last", {27'd0, ox1, oy1, ol1}, 0);
    check("rst_raw_valid", 32'(ov0), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // T1/T2: latency, pulse width, ReLU and pass-through contents
    push_exp(ta, ta_r);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_taken_first", 32'(rt1), 1);
    check("t1_valid_before", 32'(ov1), 0);
    @(negedge clk);
    check("t1_taken_second", 32'(rt1), 0);
    check("t1_valid_after", 32'(ov1), 1);
    check("t1_first_xy", {30'd0, ox1} | {30'd0, oy1}, 0);
    check("t1_pending", 32'(tp1), 1);
    @(posedge clk); #1 result_ready = 1'b0;
    wait_drain("t1_drain");
    check("t1_pulses", taken_cnt, 1);
    check("t1_pending_end", 32'(tp1), 0);

    // T3: stall on beat 3
    offer(ta, ta_r, 50);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov1 && ox1 == 2'd2 && oy1 == 2'd0) begin found = 1'b1; out_ready = 1'b0; break; end
    end
    check("t3_found_beat3", 32'(found), 1);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(ov1), 1);
      check("t3_hold_data", 32'(od1), 32'h4200);
      check("t3_hold_xy", {28'd0, ox1, oy1}, {28'd0, 2'd2, 2'd0});
      check("t3_hold_raw", 32'(od0), 32'h4200);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("t3_drain");

    // T4: FIFO fills, third tile waits for the first to drain
    out_ready = 1'b0;
    start = beats;
    tc0 = taken_cnt;
    offer(ta, ta_r, 50);
    offer(tb, tb_r, 50);
    @(negedge clk);
    check("t4_pending_full", 32'(tp1), 2);
    fork
      offer(tc, tc_r, 200);
      begin
        repeat (10) @(negedge clk);
        check("t4_pending_hold", 32'(tp1), 2);
        check("t4_pulses_full", taken_cnt - tc0, 2);
        check("t4_head_data", 32'(od1), 32'h3c00);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");
    check("t4_total_beats", beats - start, 27);
    check("t4_third_capture_beat", taken_beats - start, 10);
    check("t4_pulses", taken_cnt - tc0, 3);

    // T5: level held high is captured once
    tc0 = taken_cnt;
    push_exp(tc, tc_r);
    result_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 result_ready = 1'b0;
    @(posedge clk); #1;
    wait_drain("t5_drain");
    check("t5_pulses", taken_cnt - tc0, 1);

    // T6: reset mid-stream
    offer(ta, ta_r, 50);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov1 && ox1 == 2'd0 && oy1 == 2'd1) begin found = 1'b1; break; end
    end
    check("t6_found_beat4", 32'(found), 1);
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(ov1), 0);
    check("t6_pending", 32'(tp1), 0);
    check("t6_raw_valid", 32'(ov0), 0);
    q1.delete();
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_valid_after_rst", 32'(ov1), 0);
    @(posedge clk); #1;
    offer(tb, tb_r, 50);
    wait_drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
